// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and the initiator's pipeline register layouts.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        lock;
    } a_phase_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] wdata;
    } d_phase_t;
endpackage

// File: rtl/master_ahb_32.sv
// master_ahb_32: single-transfer request/response to pipelined AHB-Lite NONSEQ/SINGLE initiator.
module master_ahb_32 import ahb_pkg::*; (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_req,
    output logic        o_req_rdy,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_size,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_lock,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [1:0]  o_htrans,
    output logic [31:0] o_haddr,
    output logic        o_hwrite,
    output logic [2:0]  o_hsize,
    output logic [2:0]  o_hburst,
    output logic [31:0] o_hwdata,
    output logic        o_hmastlock,
    input  logic [31:0] i_hrdata,
    input  logic        i_hready,
    input  logic [1:0]  i_hresp
);
    a_phase_t    a_q, a_d;
    d_phase_t    d_q, d_d;
    logic        err_hold_q, err_hold_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        issue, addr_done, data_done, accept;

    // err_hold suppresses the address phase so the pending transfer is retried after ERROR
    assign issue     = a_q.valid && !err_hold_q;
    assign addr_done = issue && i_hready;
    assign data_done = d_q.valid && i_hready;
    assign o_req_rdy = (!a_q.valid || addr_done) && !err_hold_q && !i_hreset;
    assign accept    = i_req && o_req_rdy;

    always_comb begin
        a_d = a_q;
        if (accept)
            a_d = '{1'b1, i_req_write, i_req_addr, i_req_size, i_req_wdata, i_req_lock};
        else if (addr_done)
            a_d.valid = 1'b0;
        d_d = d_q;
        d_d.valid = addr_done || (d_q.valid && !i_hready);
        if (addr_done) begin
            d_d.write = a_q.write;
            d_d.wdata = a_q.wdata;
        end
        err_hold_d  = ((d_q.valid && i_hresp == HRESP_ERROR) || err_hold_q) && !i_hready;
        rsp_valid_d = data_done;
        rsp_err_d   = data_done && i_hresp == HRESP_ERROR;
        rsp_rdata_d = (data_done && !d_q.write) ? i_hrdata : 32'h0;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            a_q         <= '0;
            d_q         <= '0;
            err_hold_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            a_q         <= a_d;
            d_q         <= d_d;
            err_hold_q  <= err_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign o_htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_haddr     = a_q.addr;
    assign o_hwrite    = a_q.write;
    assign o_hsize     = a_q.size;
    assign o_hburst    = HBURST_SINGLE;
    assign o_hmastlock = a_q.lock;
    assign o_hwdata    = d_q.wdata;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_master_ahb_32.sv
// tb_master_ahb_32: scoreboard bench for master_ahb_32 with a bench-side AHB slave data model.
module tb_master_ahb_32;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        i_hreset, i_req, o_req_rdy, i_req_write, i_req_lock;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [2:0]  i_req_size;
    logic        o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_htrans;
    logic [31:0] o_haddr, o_hwdata, i_hrdata;
    logic        o_hwrite, o_hmastlock, i_hready;
    logic [2:0]  o_hsize, o_hburst;
    logic [1:0]  i_hresp;

    int          nvec = 0;
    int          nerr = 0;
    logic [32:0] sb_q[$];
    logic        nx_valid = 1'b0, dp_valid = 1'b0;
    logic [31:0] nx_addr = '0, dp_addr = '0;

    always #5 clk = ~clk;

    master_ahb_32 dut (
        .i_hclk(clk), .i_hreset(i_hreset), .i_req(i_req), .o_req_rdy(o_req_rdy),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
        .i_req_wdata(i_req_wdata), .i_req_lock(i_req_lock), .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_htrans(o_htrans),
        .o_haddr(o_haddr), .o_hwrite(o_hwrite), .o_hsize(o_hsize), .o_hburst(o_hburst),
        .o_hwdata(o_hwdata), .o_hmastlock(o_hmastlock), .i_hrdata(i_hrdata),
        .i_hready(i_hready), .i_hresp(i_hresp)
    );

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h200) ? 32'h1234_5678 : {a[15:0], ~a[15:0]};
    endfunction

    // Slave read-data model: tracks which address is in its data phase
    always @(negedge clk) begin
        nx_valid = (o_htrans == HTRANS_NONSEQ);
        nx_addr  = o_haddr;
    end
    always @(posedge clk) begin
        if (i_hreset) dp_valid <= 1'b0;
        else if (i_hready) begin
            dp_valid <= nx_valid;
            dp_addr  <= nx_addr;
        end
    end
    assign i_hrdata = dp_valid ? rd_val(dp_addr) : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!i_hreset && o_rsp_valid) begin
            if (sb_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("rsp_err", {31'd0, o_rsp_err}, {31'd0, e[32]});
                check("rsp_rdata", o_rsp_rdata, e[31:0]);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, input logic l);
        i_req = 1'b1; i_req_write = w; i_req_addr = a; i_req_size = s;
        i_req_wdata = d; i_req_lock = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_hreset = 1'b1; i_req = 1'b0; i_req_write = 1'b0; i_req_addr = '0;
        i_req_size = '0; i_req_wdata = '0; i_req_lock = 1'b0;
        i_hready = 1'b1; i_hresp = HRESP_OKAY;
        nxt(); nxt(); #1;
        check("rst_htrans", {30'd0, o_htrans}, {30'd0, HTRANS_IDLE});
        check("rst_haddr", o_haddr, 32'h0);
        check("rst_hwrite", {31'd0, o_hwrite}, 32'd0);
        check("rst_hsize", {29'd0, o_hsize}, 32'd0);
        check("rst_hburst", {29'd0, o_hburst}, 32'd0);
        check("rst_hwdata", o_hwdata, 32'h0);
        check("rst_hmastlock", {31'd0, o_hmastlock}, 32'd0);
        check("rst_rsp", {o_rsp_rdata[30:0], o_rsp_valid} | {31'd0, o_rsp_err}, 32'd0);
        check("rst_rdy_low", {31'd0, o_req_rdy}, 32'd0);
        i_hreset = 1'b0; #1;
        check("rst_rdy_high", {31'd0, o_req_rdy}, 32'd1);

        // Single write, zero wait
        drive(1'b1, 32'h100, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0); #1;
        check("wr_rdy", {31'd0, o_req_rdy}, 32'd1);
        sb_q.push_back({1'b0, 32'h0});
        nxt(); i_req = 1'b0; #1;
        check("wr_htrans", {30'd0, o_htrans}, {30'd0, HTRANS_NONSEQ});
        check("wr_hwrite", {31'd0, o_hwrite}, 32'd1);
        check("wr_haddr", o_haddr, 32'h100);
        nxt(); #1;
        check("wr_hwdata", o_hwdata, 32'hDEAD_BEEF);
        check("wr_idle", {30'd0, o_htrans}, {30'd0, HTRANS_IDLE});
        check("wr_rsp_early", {31'd0, o_rsp_valid}, 32'd0);
        nxt(); #1;
        check("wr_rsp_t3", {31'd0, o_rsp_valid}, 32'd1);

        // Single read, two wait states
        nxt(); drive(1'b0, 32'h200, HSIZE_WORD, 32'h0, 1'b0); #1;
        sb_q.push_back({1'b0, 32'h1234_5678});
        nxt(); i_req = 1'b0; #1;
        check("rd_htrans", {30'd0, o_htrans}, {30'd0, HTRANS_NONSEQ});
        nxt(); i_hready = 1'b0; #1;
        nxt(); #1;
        check("rd_wait_idle", {31'd0, o_rsp_valid}, 32'd0);
        nxt(); i_hready = 1'b1; #1;
        check("rd_rsp_early", {31'd0, o_rsp_valid}, 32'd0);
        nxt(); #1;
        check("rd_rsp_t5", {31'd0, o_rsp_valid}, 32'd1);

        // Back-to-back reads
        for (int i = 0; i < 7; i++) begin
            nxt();
            if (i < 4) begin
                drive(1'b0, 32'(4 * i), HSIZE_WORD, 32'h0, 1'b0);
                sb_q.push_back({1'b0, rd_val(32'(4 * i))});
            end else i_req = 1'b0;
            #1;
            if (i < 4) check("b2b_rdy", {31'd0, o_req_rdy}, 32'd1);
            if (i >= 1 && i <= 4) begin
                check("b2b_htrans", {30'd0, o_htrans}, {30'd0, HTRANS_NONSEQ});
                check("b2b_haddr", o_haddr, 32'(4 * (i - 1)));
            end
            if (i >= 3) check("b2b_rsp", {31'd0, o_rsp_valid}, 32'd1);
        end

        // ERROR with a pending transfer
        nxt(); drive(1'b1, 32'h10, HSIZE_WORD, 32'hCAFE_0010, 1'b0);
        sb_q.push_back({1'b1, 32'h0});
        nxt(); drive(1'b0, 32'h14, HSIZE_WORD, 32'h0, 1'b0); #1;
        check("err_rdy2", {31'd0, o_req_rdy}, 32'd1);
        sb_q.push_back({1'b0, rd_val(32'h14)});
        nxt(); i_req = 1'b0; i_hresp = HRESP_ERROR; i_hready = 1'b0; #1;
        check("err_c1_haddr", o_haddr, 32'h14);
        nxt(); i_hready = 1'b1; #1;
        check("err_c2_idle", {30'd0, o_htrans}, {30'd0, HTRANS_IDLE});
        check("err_c2_rdy", {31'd0, o_req_rdy}, 32'd0);
        nxt(); i_hresp = HRESP_OKAY; #1;
        check("err_rsp", {31'd0, o_rsp_valid}, 32'd1);
        check("err_reissue", {30'd0, o_htrans}, {30'd0, HTRANS_NONSEQ});
        check("err_reissue_addr", o_haddr, 32'h14);
        nxt(); #1;
        nxt(); #1;
        check("err_retry_rsp", {31'd0, o_rsp_valid}, 32'd1);

        // Reset mid-transfer
        nxt(); drive(1'b0, 32'h300, HSIZE_WORD, 32'h0, 1'b1);
        nxt(); i_req = 1'b0;
        nxt(); i_hreset = 1'b1; #1;
        check("mrst_rdy", {31'd0, o_req_rdy}, 32'd0);
        nxt(); i_hreset = 1'b0; #1;
        check("mrst_htrans", {30'd0, o_htrans}, {30'd0, HTRANS_IDLE});
        check("mrst_haddr", o_haddr, 32'h0);
        check("mrst_lock", {31'd0, o_hmastlock}, 32'd0);
        check("mrst_rsp", {31'd0, o_rsp_valid}, 32'd0);
        check("mrst_rdy_hi", {31'd0, o_req_rdy}, 32'd1);
        nxt(); #1;
        check("mrst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);

        // Lock and size passthrough
        drive(1'b1, 32'h3, HSIZE_BYTE, 32'h0000_00AB, 1'b1);
        sb_q.push_back({1'b0, 32'h0});
        nxt(); i_req = 1'b0; #1;
        check("lk_htrans", {30'd0, o_htrans}, {30'd0, HTRANS_NONSEQ});
        check("lk_hsize", {29'd0, o_hsize}, {29'd0, HSIZE_BYTE});
        check("lk_haddr", o_haddr, 32'h3);
        check("lk_lock", {31'd0, o_hmastlock}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("lk_hburst", {29'd0, o_hburst}, {29'd0, HBURST_SINGLE});
            nxt(); #1;
        end

        nxt();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
